// File: rtl/usr_shift_sequencer.sv
// Sequencer for an external universal shift register: accepts LOAD/SHR/SHL/ROTR
// commands, steps the register one mode per cycle and pulses done with the result.
module usr_shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [1:0]       usr_s,
    output logic [WIDTH-1:0] usr_d,
    input  logic [WIDTH-1:0] usr_q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_ROTR = 2'b11
    } op_t;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_PLOAD = 2'b11;

    state_t           state;
    op_t              op_q;
    logic [AMT_W-1:0] amt_q;
    logic [WIDTH-1:0] data_q;
    logic [AMT_W-1:0] count;

    // Rotation is done through a parallel load of the pre-rotated value.
    function automatic logic [1:0] shift_mode(input op_t op);
        case (op)
            OP_SHR:  return MODE_RIGHT;
            OP_SHL:  return MODE_LEFT;
            OP_ROTR: return MODE_PLOAD;
            default: return MODE_HOLD;
        endcase
    endfunction

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // flop samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            op_q      <= OP_LOAD;
            amt_q     <= '0;
            data_q    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            usr_s     <= MODE_HOLD;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= op_t'(cmd_op);
                        amt_q     <= cmd_amt;
                        data_q    <= cmd_data;
                        count     <= cmd_amt;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (op_t'(cmd_op) == OP_LOAD) begin
                            state <= S_LOAD;
                            usr_s <= MODE_PLOAD;
                        end else if (cmd_amt == '0) begin
                            // Zero-step shift: report the untouched register contents.
                            state <= S_DONE;
                            done  <= 1'b1;
                            usr_s <= MODE_HOLD;
                        end else begin
                            state <= S_SHIFT;
                            usr_s <= shift_mode(op_t'(cmd_op));
                        end
                    end
                end
                S_LOAD: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    usr_s <= MODE_HOLD;
                end
                S_SHIFT: begin
                    count <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        usr_s <= MODE_HOLD;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    usr_s     <= MODE_HOLD;
                end
            endcase
        end
    end

    // usr_d must track usr_q in the same cycle, so it is a mux off registered state.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        usr_d = '0;
        case (state)
            S_LOAD:  usr_d = data_q;
            S_SHIFT: usr_d = (op_q == OP_ROTR) ? {usr_q[0], usr_q[WIDTH-1:1]} : usr_q;
            default: usr_d = '0;
        endcase
    end

    assign res_data = done ? usr_q : '0;

    // amt_q is kept for observability of the accepted command; it does not steer logic.
    logic unused_amt;
    assign unused_amt = ^amt_q;

endmodule
